// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the FDIV issue/writeback controller
package fp_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RESP
    } state_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int FLAGS_W = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
    } fp_cls_t;

    // Exception flags known before the divide runs; OF/UF/NX are never raised here.
    function automatic logic [FLAGS_W-1:0] div_flags(input fp_cls_t a, input fp_cls_t b);
        logic [FLAGS_W-1:0] f;
        f          = '0;
        f[FLAG_NV] = a.snan | b.snan | (a.zero & b.zero) | (a.inf & b.inf);
        f[FLAG_DZ] = b.zero & ~(a.zero | a.inf | a.qnan | a.snan);
        f[FLAG_OF] = 1'b0;
        f[FLAG_UF] = 1'b0;
        f[FLAG_NX] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/fp_class.sv
// rtl/fp_class.sv - classifies a single-precision magnitude as zero, inf, qNaN or sNaN
module fp_class
    import fp_div_pkg::*;
(
    input  logic [30:0] mag,
    output fp_cls_t     cls
);

    logic exp_max;
    logic frac_nz;

    assign exp_max  = &mag[30:23];
    assign frac_nz  = |mag[22:0];

    assign cls.zero = ~|mag;
    assign cls.inf  = exp_max & ~frac_nz;
    assign cls.qnan = exp_max & mag[22];
    assign cls.snan = exp_max & frac_nz & ~mag[22];

endmodule

// File: rtl/fp_div_ctrl.sv
// rtl/fp_div_ctrl.sv - single-outstanding FDIV controller between decode, divider and writeback
module fp_div_ctrl
    import fp_div_pkg::*;
#(
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 15
) (
    input  logic               in_Clk,
    input  logic               in_Rst,
    input  logic               in_req_valid,
    output logic               out_req_ready,
    input  logic [31:0]        in_numA,
    input  logic [31:0]        in_numB,
    input  logic [RD_W-1:0]    in_rd,
    input  logic               in_flush,
    output logic               out_div_start,
    output logic [31:0]        out_div_numA,
    output logic [31:0]        out_div_numB,
    input  logic               in_div_stall,
    input  logic [31:0]        in_div_result,
    output logic               out_wb_valid,
    input  logic               in_wb_ready,
    output logic [RD_W-1:0]    out_wb_rd,
    output logic [31:0]        out_wb_data,
    output logic [FLAGS_W-1:0] out_wb_flags,
    output logic               out_busy
);

    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       timeout;
    logic       kill;
    logic       kill_now;
    logic [3:0] to_cnt;
    fp_cls_t    cls_a;
    fp_cls_t    cls_b;

    fp_class u_cls_a (.mag(in_numA[30:0]), .cls(cls_a));
    fp_class u_cls_b (.mag(in_numB[30:0]), .cls(cls_b));

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A killed op still waits for the divider to drop stall before going idle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        timeout   = 1'b0;
        kill_now  = kill | in_flush;
        case (state)
            ST_IDLE: begin
                if (in_req_valid && !in_flush) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (in_div_stall) begin
                    state_nxt = ST_WAIT_LO;
                end else if (to_cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = kill_now ? ST_IDLE : ST_RESP;
                end
            end
            ST_WAIT_LO: begin
                if (!in_div_stall) begin
                    state_nxt = kill_now ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (in_wb_ready || in_flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            out_div_numA <= '0;
            out_div_numB <= '0;
            out_wb_rd    <= '0;
            out_wb_flags <= '0;
            out_wb_data  <= '0;
            to_cnt       <= '0;
            kill         <= 1'b0;
        end else begin
            if (accept) begin
                out_div_numA <= in_numA;
                out_div_numB <= in_numB;
                out_wb_rd    <= in_rd;
                out_wb_flags <= div_flags(cls_a, cls_b);
            end
            if (state == ST_ISSUE) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT_HI && !in_div_stall && !timeout) begin
                to_cnt <= to_cnt + 4'd1;
            end
            if (state == ST_WAIT_LO && !in_div_stall) begin
                out_wb_data <= in_div_result;
            end
            // Divider never went busy: answer with the canonical NaN as invalid.
            if (timeout) begin
                out_wb_data           <= CANON_NAN;
                out_wb_flags[FLAG_NV] <= 1'b1;
            end
            if (in_flush && (state == ST_ISSUE || state == ST_WAIT_HI || state == ST_WAIT_LO)) begin
                kill <= 1'b1;
            end
            if (state_nxt == ST_IDLE) begin
                kill <= 1'b0;
            end
        end
    end

    assign out_req_ready = (state == ST_IDLE);
    assign out_div_start = (state == ST_ISSUE);
    assign out_wb_valid  = (state == ST_RESP);
    assign out_busy      = (state != ST_IDLE);

endmodule

// File: doc/fp_div_ctrl.md
FP_DIV_CTRL -- requirements
Module: fp_div_ctrl

Interface
REQ-001 SHALL have parameter RD_W, default 5: destination register index width.
REQ-002 SHALL have parameter TIMEOUT, default 15: max cycles in WAIT_HI before abort; range 1..15, 4-bit counter.
REQ-003 Clocking SHALL be fixed as: one clock; reset is asynchronous and active-high.
REQ-004 in_Clk  input  1  sole clock, rising edge.
REQ-005 in_Rst  input  1  asynchronous active-high reset.
REQ-006 in_req_valid  input  1  decode presents FDIV request.
REQ-007 out_req_ready  output  1  controller accepts request.
REQ-008 in_numA / in_numB  input  32  IEEE-754 dividend / divisor.
REQ-009 in_rd  input  RD_W  destination register.
REQ-010 in_flush  input  1  pipeline kill of in-flight op.
REQ-011 out_div_start  output  1  one-cycle start pulse to divider.
REQ-012 out_div_numA / out_div_numB  output  32  operands held stable to divider.
REQ-013 in_div_stall / in_div_result  input  1 / 32  divider busy flag and result.
REQ-014 out_wb_valid  output  1  / in_wb_ready  input  1  writeback handshake.
REQ-015 out_wb_rd / out_wb_data / out_wb_flags  output  RD_W / 32 / 5  writeback payload; flags {NV,DZ,OF,UF,NX}.
REQ-016 out_busy  output  1  high whenever state != IDLE (hazard stall to pipeline).

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
REQ-018 IDLE: out_req_ready=1; valid&ready&!in_flush captures operands, rd, flags -> ISSUE; in_flush blocks acceptance.
REQ-019 ISSUE: out_div_start=1 exactly one cycle -> WAIT_HI; timeout counter cleared.
REQ-020 WAIT_HI: in_div_stall=1 -> WAIT_LO; else counter+1; counter==TIMEOUT-1 -> RESP with data 32'h7FC00000, NV=1.
REQ-021 WAIT_LO: in_div_stall=0 -> in_div_result captured into out_wb_data -> RESP (or IDLE if killed).
REQ-022 RESP: out_wb_valid=1, payload stable until in_wb_ready; handshake -> IDLE.
REQ-023 Latency: out_wb_valid rises the cycle after stall observed low; with team FP_Div, 7 cycles after acceptance edge.
REQ-024 out_div_start SHALL never assert outside ISSUE; out_div_num* SHALL hold captured values from ISSUE until return to IDLE.
REQ-025 Flags from captured operands: NV = sNaN operand, 0/0, Inf/Inf; DZ = B zero and A finite nonzero; OF/UF/NX = 0.
REQ-026 in_flush in ISSUE/WAIT_HI/WAIT_LO SHALL set kill flag; divider handshake completes, no wb_valid, return to IDLE.
REQ-027 in_flush in RESP SHALL drop out_wb_valid next cycle and go IDLE; flush and wb_ready same cycle = writeback counted done.
REQ-028 No new request accepted before RESP handshake or killed op completes (single outstanding op).

Reset
REQ-029 in_Rst SHALL force IDLE asynchronously, mid-operation included.
REQ-030 Reset values: out_req_ready=1 after release, out_div_start=0, out_wb_valid=0, out_busy=0, out_wb_data=0, out_wb_rd=0, out_wb_flags=0, out_div_num*=0, counter=0, kill=0.
REQ-031 Divider reset is external; controller SHALL NOT assume divider idle until in_div_stall=0.

Structure
REQ-032 Shared package fp_div_pkg SHALL hold state encoding, canonical NaN 32'h7FC00000, flag bit indices.
REQ-033 One sub-module fp_class SHALL classify a 32-bit operand (zero, inf, qNaN, sNaN); two instances.

Verification
REQ-034 A=40C00000, B=40000000 with FP_Div -> wb_valid 7 cycles after accept, data 40400000, flags 0, rd echoed.
REQ-035 A=3F800000, B=00000000 -> data 7F800000, flags DZ=1 only.
REQ-036 A=B=00000000 -> data 7FC00000, NV=1.
REQ-037 in_flush pulse in WAIT_LO -> no wb_valid; req_ready returns 1 cycle after stall low; one start pulse total.
REQ-038 in_wb_ready low 5 cycles in RESP -> payload stable, req_ready 0, busy 1, no second start.
REQ-039 in_div_stall tied 0, TIMEOUT=15 -> wb_valid after 15 WAIT_HI cycles, data 7FC00000, NV=1.
